// File: rtl/apple2_track_bram.sv
// apple2_track_bram: one-track floppy buffer filled from the SD host, read by the disk controller.
// Optional controller write port enabled with `DISK_WRITE_EN.
module apple2_track_bram #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 14,
  parameter int SECTORS = 13
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [5:0]        track,
  input  logic              img_mounted,
  input  logic [63:0]       img_size,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  input  logic              sd_ack,
  input  logic [8:0]        sd_buff_addr,
  input  logic [DATA_W-1:0] sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic              cpu_wait,
  input  logic [ADDR_W-1:0] fd_track_addr,
  output logic [DATA_W-1:0] fd_data_in,
  input  logic              fd_write_disk,
  input  logic [DATA_W-1:0] fd_data_do
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t r_state;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_fd_data;
  logic [DATA_W-1:0] w_rd_next;
  logic [5:0]        r_cur_track;
  logic [3:0]        r_track_sec;
  logic [31:0]       r_lba;
  logic              r_mounted, r_old_ack, r_sd_rd, r_cpu_wait;
  logic              w_we_a;
  logic [ADDR_W-1:0] w_addr_a;
  assign w_we_a   = sd_buff_wr & sd_ack;
  assign w_addr_a = ADDR_W'({1'b0, r_track_sec, sd_buff_addr});
  assign sd_lba     = r_lba;
  assign sd_rd      = r_sd_rd;
  assign cpu_wait   = r_cpu_wait;
  assign fd_data_in = r_fd_data;
`ifdef DISK_WRITE_EN
  logic w_we_b;
  assign w_we_b    = fd_write_disk & ~(w_we_a & (w_addr_a == fd_track_addr));
  assign w_rd_next = !fd_write_disk ? r_mem[fd_track_addr] : w_we_b ? fd_data_do : sd_buff_dout;
`else
  logic w_unused;
  assign w_unused  = ^{fd_write_disk, fd_data_do};
  assign w_rd_next = r_mem[fd_track_addr];
`endif
  // RAM writes: loader side always, controller side only when enabled and not colliding with the loader
  always_ff @(posedge clk_sys) begin
    if (w_we_a) r_mem[w_addr_a] <= sd_buff_dout;
`ifdef DISK_WRITE_EN
    if (w_we_b) r_mem[fd_track_addr] <= fd_data_do;
`endif
  end
  // Registered controller read port
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_fd_data <= '0;
    else          r_fd_data <= w_rd_next;
  end
  // Track loader: detects track/mount changes and walks the SD host through all sectors
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cur_track <= 6'h3F;
      r_mounted   <= 1'b0;
      r_track_sec <= '0;
      r_lba       <= '0;
      r_old_ack   <= 1'b0;
      r_sd_rd     <= 1'b0;
      r_cpu_wait  <= 1'b0;
    end else begin
      r_old_ack <= sd_ack;
      if (img_mounted) r_mounted <= 1'b1;
      case (r_state)
        IDLE: if ((r_cur_track != track) || (r_mounted && !img_mounted)) begin
          r_cur_track <= track;
          r_mounted   <= 1'b0;
          if (img_size != 64'd0) begin
            r_track_sec <= '0;
            r_lba       <= 32'd13 * {26'd0, track};
            r_sd_rd     <= 1'b1;
            r_cpu_wait  <= 1'b1;
            r_state     <= LOAD;
          end
        end
        LOAD: if (sd_ack && !r_old_ack) begin
          r_lba <= r_lba + 32'd1;
          if (r_track_sec >= 4'(SECTORS-1)) r_sd_rd <= 1'b0;
        end else if (!sd_ack && r_old_ack) begin
          r_track_sec <= r_track_sec + 4'd1;
          if (!r_sd_rd) begin
            r_state    <= IDLE;
            r_cpu_wait <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apple2_track_bram.sv
// tb_apple2_track_bram: table-driven and randomized checks of the track loader and read port.
module tb_apple2_track_bram;
  logic        clk_sys = 0, reset_n = 0;
  logic [5:0]  track = 0;
  logic        img_mounted = 0;
  logic [63:0] img_size = 0;
  logic [31:0] sd_lba;
  logic        sd_rd, cpu_wait;
  logic        sd_ack = 0, sd_buff_wr = 0;
  logic [8:0]  sd_buff_addr = 0;
  logic [7:0]  sd_buff_dout = 0;
  logic [13:0] fd_track_addr = 0;
  logic [7:0]  fd_data_in;
  logic        fd_write_disk = 0;
  logic [7:0]  fd_data_do = 0;
  logic [7:0]  ref_mem [0:16383];
  int n_checks = 0, n_err = 0;

  apple2_track_bram dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track), .img_mounted(img_mounted),
    .img_size(img_size), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .cpu_wait(cpu_wait), .fd_track_addr(fd_track_addr), .fd_data_in(fd_data_in),
    .fd_write_disk(fd_write_disk), .fd_data_do(fd_data_do)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Host model: serves nsec sectors of track t, recording every byte in ref_mem
  task automatic serve(input int t, input int nsec);
    logic [7:0] d;
    for (int s = 0; s < nsec; s++) begin
      @(negedge clk_sys);
      chk("lba_before_sector", sd_lba, 64'(13 * t + s));
      chk("rd_before_sector", sd_rd, 1);
      chk("wait_during_load", cpu_wait, 1);
      sd_ack = 1;
      for (int i = 0; i < 512; i++) begin
        if (i > 0) @(negedge clk_sys);
        d = 8'($urandom);
        sd_buff_addr = 9'(i);
        sd_buff_dout = d;
        sd_buff_wr = 1;
        ref_mem[s * 512 + i] = d;
      end
      @(negedge clk_sys);
      chk("rd_after_rise", sd_rd, (s < 12) ? 1 : 0);
      chk("wait_after_rise", cpu_wait, 1);
      sd_ack = 0;
      sd_buff_addr = 9'd5;
      sd_buff_dout = ~ref_mem[s * 512 + 5];
      @(negedge clk_sys);
      sd_buff_wr = 0;
      chk("wait_after_fall", cpu_wait, (s < 12) ? 1 : 0);
    end
  endtask

  task automatic rd(input logic [13:0] a, input bit w, input logic [7:0] d);
    logic [7:0] exp;
    @(negedge clk_sys);
    fd_track_addr = a;
    fd_write_disk = w;
    fd_data_do = d;
    exp = ref_mem[a];
`ifdef DISK_WRITE_EN
    if (w) begin
      ref_mem[a] = d;
      exp = d;
    end
`endif
    @(negedge clk_sys);
    fd_write_disk = 0;
    chk("port_b_read", fd_data_in, exp);
  endtask

  typedef struct {
    logic [5:0]  trk;
    logic [63:0] size;
    bit          load;
    logic [31:0] lba;
  } vec_t;
  vec_t vecs [5];
  int t_rand;

  initial begin
    vecs[0] = '{6'd0,  64'd143360, 1'b1, 32'd0};
    vecs[1] = '{6'd5,  64'd143360, 1'b1, 32'd65};
    vecs[2] = '{6'd9,  64'd0,      1'b0, 32'd0};
    vecs[3] = '{6'd9,  64'd143360, 1'b0, 32'd0};
    vecs[4] = '{6'd34, 64'd143360, 1'b1, 32'd442};
    img_size = 64'd143360;
    repeat (3) @(negedge clk_sys);
    chk("reset_sd_rd", sd_rd, 0);
    chk("reset_cpu_wait", cpu_wait, 0);
    chk("reset_sd_lba", sd_lba, 0);
    chk("reset_fd_data", fd_data_in, 0);
    reset_n = 1;
    for (int v = 0; v < 5; v++) begin
      track = vecs[v].trk;
      img_size = vecs[v].size;
      repeat (2) @(negedge clk_sys);
      chk("vec_sd_rd", sd_rd, vecs[v].load);
      chk("vec_cpu_wait", cpu_wait, vecs[v].load);
      if (vecs[v].load) begin
        chk("vec_sd_lba", sd_lba, vecs[v].lba);
        serve(int'(vecs[v].trk), 13);
        repeat (2) @(negedge clk_sys);
        chk("vec_idle_after_load", cpu_wait, 0);
      end
      if (v == 0) begin
        rd(14'h0200, 0, 0);
        rd(14'h19FF, 0, 0);
        for (int s = 0; s < 13; s++) rd(14'(s * 512 + 5), 0, 0);
      end
    end
    img_mounted = 1;
    @(negedge clk_sys);
    img_mounted = 0;
    repeat (2) @(negedge clk_sys);
    chk("mount_sd_rd", sd_rd, 1);
    chk("mount_sd_lba", sd_lba, 442);
    serve(34, 13);
    @(negedge clk_sys);
    track = 6'd7;
    img_mounted = 1;
    @(negedge clk_sys);
    img_mounted = 0;
    chk("simul_sd_rd", sd_rd, 1);
    chk("simul_sd_lba", sd_lba, 91);
    serve(7, 13);
    repeat (3) @(negedge clk_sys);
    chk("simul_single_load", sd_rd, 0);
    chk("simul_wait_clear", cpu_wait, 0);
    track = 6'd20;
    repeat (2) @(negedge clk_sys);
    chk("pre_reset_sd_rd", sd_rd, 1);
    serve(20, 4);
    reset_n = 0;
    #1;
    chk("midload_reset_sd_rd", sd_rd, 0);
    chk("midload_reset_wait", cpu_wait, 0);
    chk("midload_reset_lba", sd_lba, 0);
    chk("midload_reset_fd_data", fd_data_in, 0);
    @(negedge clk_sys);
    reset_n = 1;
    rd(14'h1000, 0, 0);
    rd(14'h0003, 0, 0);
    chk("reload_sd_rd", sd_rd, 1);
    chk("reload_wait", cpu_wait, 1);
    chk("reload_lba", sd_lba, 260);
    serve(20, 13);
    t_rand = (20 + int'($urandom_range(1, 40))) % 64;
    @(negedge clk_sys);
    track = 6'(t_rand);
    repeat (2) @(negedge clk_sys);
    chk("rand_sd_lba", sd_lba, 64'(13 * t_rand));
    serve(t_rand, 13);
    for (int k = 0; k < 200; k++)
      rd(14'($urandom_range(0, 6655)), bit'($urandom_range(0, 3) == 0), 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/apple2_track_bram.md
# apple2_track_bram

Floppy track buffer for the Apple II core. It holds one 13-sector track of the mounted disk image in a dual-port block RAM. It fetches the track from the SD block interface whenever the drive's head track changes or a new image is mounted. It stalls the CPU while loading and serves nibble reads to the disk controller through a registered read port.

## Interface
Parameters:
- `DATA_W`, 8: byte width of both RAM ports.
- `ADDR_W`, 14: RAM address width; depth is 2^ADDR_W.
- `SECTORS`, 13: 512-byte sectors per track (6656 bytes).

Ports:
- `clk_sys` in 1: single clock for all logic and both RAM ports.
- `reset_n` in 1: asynchronous, active-low reset.
- `track` in 6: current head track from the disk controller.
- `img_mounted` in 1: one-cycle pulse when an image is mounted.
- `img_size` in 64: image size in bytes; 0 means no image.
- `sd_lba` out 32: sector number requested from the SD host.
- `sd_rd` out 1: read request to the SD host.
- `sd_ack` in 1: host acknowledge; high for the duration of one sector transfer.
- `sd_buff_addr` in 9: byte offset within the sector being transferred.
- `sd_buff_dout` in 8: byte from the host.
- `sd_buff_wr` in 1: byte strobe from the host.
- `cpu_wait` out 1: CPU stall while the track is loading.
- `fd_track_addr` in 14: controller byte address within the track.
- `fd_data_in` out 8: byte read from the track.
- `fd_write_disk` in 1: controller write strobe (used only with `DISK_WRITE_EN`).
- `fd_data_do` in 8: controller write data.

## Operation
- RAM port A is the loader side.
  - Address is {1'b0, track_sec[3:0], sd_buff_addr}.
  - Write enable is `sd_buff_wr & sd_ack`.
- RAM port B is the controller side.
  - Address is `fd_track_addr`; read data goes to `fd_data_in`.
- Internal state:
  - `cur_track` (6b), reset value 6'h3F.
  - `mounted` flag: set by `img_mounted`, sticky until consumed.
  - `track_sec` (4b), `lba` (32b), `old_ack`.
- FSM has two states, IDLE and LOAD; reset state is IDLE.
- IDLE: a load trigger is (`cur_track != track`) or (`mounted & ~img_mounted`). On a trigger:
  - `cur_track <= track`, `mounted <= 0`.
  - If `img_size != 0`: `track_sec <= 0`, `lba <= 13*track` (computed at 32-bit width), `sd_rd <= 1`, `cpu_wait <= 1`, go to LOAD.
  - If `img_size == 0`: stay in IDLE, no request.
- LOAD, on a rising `sd_ack` edge:
  - `lba <= lba + 1`.
  - If `track_sec >= SECTORS-1`, then `sd_rd <= 0`.
- LOAD, on a falling `sd_ack` edge:
  - `track_sec <= track_sec + 1`.
  - If `sd_rd == 0`: go to IDLE and `cpu_wait <= 0`.
- `cpu_wait` stays high for the whole track, covering all 13 sectors.
- A track change during LOAD is ignored until IDLE; the next IDLE cycle then triggers a reload.
- `sd_lba = lba` at all times.
- Reset, including mid-load:
  - state IDLE, `sd_rd = 0`, `cpu_wait = 0`, `sd_lba = 0`, `track_sec = 0`, `mounted = 0`, `cur_track = 6'h3F`.
  - RAM contents are preserved.
  - `fd_data_in` register resets to 0.

## Timing
- `fd_data_in` is registered: valid 1 cycle after `fd_track_addr` is presented.
- Port A write occurs on the `clk_sys` edge where `sd_buff_wr & sd_ack` is high.
- `sd_rd` and `cpu_wait` assert 1 cycle after the trigger is sampled in IDLE.
- Ack edges are detected against `old_ack`, so responses come 1 cycle after the edge.
- `cpu_wait` deasserts 1 cycle after the 13th falling `sd_ack` edge.
- Simultaneous `img_mounted` pulse and track change: this is one trigger and causes a single load. `mounted` is cleared.

## Configuration
- `DISK_WRITE_EN` defined:
  - Port B writes `fd_data_do` at `fd_track_addr` when `fd_write_disk` is high.
  - `fd_data_in` returns the written data in that cycle (write-first).
  - On a same-cycle, same-address collision with port A, port A's data wins.
- `DISK_WRITE_EN` undefined: port B is read-only and `fd_write_disk` / `fd_data_do` are ignored.

## Test plan
- Reset, `img_size = 143360`, `track = 0`:
  - `sd_rd = 1`, `cpu_wait = 1`, `sd_lba = 0` within 2 cycles.
  - Serve 13 ack pulses of 512 bytes each: `sd_rd` drops on the 13th rising ack and `cpu_wait` clears after the 13th falling ack.
- After the load in the first scenario, read back from port B:
  - `fd_track_addr = 0x0200` returns sector-1 byte 0, valid next cycle.
  - `fd_track_addr = 0x19FF` returns sector-12 byte 511.
- `track` 0 -> 5:
  - Expect `sd_lba = 65`; successive requests use LBAs 66 to 77.
- `img_size = 0` with a track change:
  - No `sd_rd` and no `cpu_wait`; `cur_track` is still updated.
- `img_mounted` pulse with `track` unchanged:
  - A reload of the same track occurs with `sd_lba = 13*track`.
- `reset_n` low after the 4th sector:
  - `sd_rd = 0` and `cpu_wait = 0` immediately.
  - After release, the track reloads from sector 0 because `cur_track` = 6'h3F.
